// File: rtl/mult_insertion.sv
// ---------------------------------------------------------------------------
// mult_insertion
//
// Write-side counterpart of the RLS word-select mux. This block builds and
// holds a packed N-bit vector made of NW = N/nBits words, each nBits wide.
// Word i sits at out[i*nBits +: nBits] with [0:N-1] (MSB-first) indexing, so
// word 0 occupies the leftmost bits.
//
// Words can be loaded in two ways:
//   - an auto-incrementing stream with a valid/ready handshake
//     (start / in_valid / in_ready / in_data), or
//   - direct addressed writes (wr_en / wr_sel / wr_data).
//
// Ports:
//   clk       system clock; all state updates on the rising edge
//   rst       synchronous, active-high reset
//   start     one-cycle pulse; restarts the stream fill at word 0
//   in_valid  a stream word is present on in_data
//   in_ready  the block can accept a stream word (combinational from state)
//   in_data   stream word, [0:nBits-1]
//   wr_en     addressed write strobe
//   wr_sel    addressed word index
//   wr_data   addressed write word, [0:nBits-1]
//   out       packed vector, [0:N-1]
//   count     index of the next stream word (0..NW)
//   full      all NW words filled by the stream since the last start/reset
//   done      one-cycle pulse on the cycle full rises
//   sel_err   one-cycle pulse for an out-of-range addressed write
// ---------------------------------------------------------------------------
module mult_insertion #(
  parameter int N     = 100,
  parameter int nBits = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:nBits-1] in_data,
  input  logic             wr_en,
  input  logic [31:0]      wr_sel,
  input  logic [0:nBits-1] wr_data,
  output logic [0:N-1]     out,
  output logic [31:0]      count,
  output logic             full,
  output logic             done,
  output logic             sel_err
);

  localparam int NW = N / nBits;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [0:N-1]    out_q, out_d;
  logic [31:0]     count_q, count_d;
  logic            full_q, full_d;
  logic            done_q, done_d;
  logic            sel_err_q, sel_err_d;
  logic            xfer;

  // Ready depends on state only, never on the inputs, so no combinational
  // path exists from in_valid back to in_ready.
  assign in_ready = (state_q == FILL);
  assign xfer     = in_valid && in_ready;

  // Next-state and datapath logic.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    state_d   = state_q;
    out_d     = out_q;
    count_d   = count_q;
    full_d    = full_q;
    done_d    = 1'b0;
    sel_err_d = 1'b0;

    // Stream transfer: write the word at the current count, then advance.
    // Tail bits beyond NW*nBits are never addressed by these loops.
    if (xfer) begin
      for (int i = 0; i < NW; i++) begin
        if (count_q == i) begin
          out_d[i*nBits +: nBits] = in_data;
        end
      end
      if (count_q == NW - 1) begin
        count_d = NW;
        state_d = FULL;
        full_d  = 1'b1;
        done_d  = 1'b1;
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    // Addressed write comes after the stream write so that it wins when both
    // target the same word; count still advances from the stream side.
    if (wr_en) begin
      if (wr_sel < NW) begin
        for (int i = 0; i < NW; i++) begin
          if (wr_sel == i) begin
            out_d[i*nBits +: nBits] = wr_data;
          end
        end
      end else begin
        sel_err_d = 1'b1;
      end
    end

    // start overrides the count/state bookkeeping (including a final
    // transfer in the same cycle) but keeps any word just written.
    if (start) begin
      count_d = 32'd0;
      full_d  = 1'b0;
      done_d  = 1'b0;
      state_d = FILL;
    end
  end

  // State register with synchronous reset; reset has priority over all inputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= FILL;
      out_q     <= '0;
      count_q   <= 32'd0;
      full_q    <= 1'b0;
      done_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      count_q   <= count_d;
      full_q    <= full_d;
      done_q    <= done_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign out     = out_q;
  assign count   = count_q;
  assign full    = full_q;
  assign done    = done_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mult_insertion.sv
// ---------------------------------------------------------------------------
// tb_mult_insertion
//
// Directed bench for mult_insertion with the default N=100, nBits=32 (NW=3).
// Each stimulus step drives the inputs on the falling edge and queues the
// hand-computed state expected right after the following rising edge. An
// independent monitor pops one expectation per rising edge (sampled 1 time
// unit later) and compares every output against it.
// ---------------------------------------------------------------------------
module tb_mult_insertion;

  localparam int N     = 100;
  localparam int NBITS = 32;

  typedef struct {
    string       name;
    logic [0:N-1] out;
    logic [31:0] count;
    logic        full;
    logic        done;
    logic        sel_err;
    logic        in_ready;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [0:NBITS-1] in_data;
  logic             wr_en;
  logic [31:0]      wr_sel;
  logic [0:NBITS-1] wr_data;
  logic [0:N-1]     out;
  logic [31:0]      count;
  logic             full;
  logic             done;
  logic             sel_err;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  mult_insertion #(.N(N), .nBits(NBITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .out      (out),
    .count    (count),
    .full     (full),
    .done     (done),
    .sel_err  (sel_err)
  );

  always #5 clk = ~clk;

  // Word 0 is leftmost; the 4 tail bits are always zero.
  function automatic logic [0:N-1] pack(input logic [31:0] w0, w1, w2);
    return {w0, w1, w2, 4'b0000};
  endfunction

  task automatic check(input string name, input string field,
                       input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s.%s: got %h expected %h", name, field, act, req);
    end
  endtask

  // Monitor: one expectation is consumed per rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.name, "out",      128'(out),      128'(e.out));
      check(e.name, "count",    128'(count),    128'(e.count));
      check(e.name, "full",     128'(full),     128'(e.full));
      check(e.name, "done",     128'(done),     128'(e.done));
      check(e.name, "sel_err",  128'(sel_err),  128'(e.sel_err));
      check(e.name, "in_ready", 128'(in_ready), 128'(e.in_ready));
    end
  end

  // One cycle of stimulus plus the state expected after the next rising edge.
  task automatic step(input string nm,
                      input logic r, input logic st,
                      input logic v, input logic [31:0] d,
                      input logic we, input logic [31:0] ws, input logic [31:0] wd,
                      input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                      input logic [31:0] ecnt, input logic efull, input logic edone,
                      input logic eerr, input logic erdy);
    exp_t e;
    @(negedge clk);
    rst      = r;
    start    = st;
    in_valid = v;
    in_data  = d;
    wr_en    = we;
    wr_sel   = ws;
    wr_data  = wd;
    e.name     = nm;
    e.out      = pack(e0, e1, e2);
    e.count    = ecnt;
    e.full     = efull;
    e.done     = edone;
    e.sel_err  = eerr;
    e.in_ready = erdy;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    wr_en = 1'b0; wr_sel = '0; wr_data = '0;

    //    name           rst st v  data           we ws            wdata          w0             w1             w2             cnt full done err rdy
    step("reset",        1, 0, 0, 32'h0,        0, 32'd0,        32'h0,        32'h0,        32'h0,        32'h0,        0,  0,   0,   0,  1);
    step("push1",        0, 0, 1, 32'h11111111, 0, 32'd0,        32'h0,        32'h11111111, 32'h0,        32'h0,        1,  0,   0,   0,  1);
    step("push2",        0, 0, 1, 32'h22222222, 0, 32'd0,        32'h0,        32'h11111111, 32'h22222222, 32'h0,        2,  0,   0,   0,  1);
    step("push3",        0, 0, 1, 32'h33333333, 0, 32'd0,        32'h0,        32'h11111111, 32'h22222222, 32'h33333333, 3,  1,   1,   0,  0);
    for (int i = 0; i < 5; i++)
      step("bp_full",    0, 0, 1, 32'hDEADBEEF, 0, 32'd0,        32'h0,        32'h11111111, 32'h22222222, 32'h33333333, 3,  1,   0,   0,  0);
    step("wr_sel1",      0, 0, 0, 32'h0,        1, 32'd1,        32'hCAFEF00D, 32'h11111111, 32'hCAFEF00D, 32'h33333333, 3,  1,   0,   0,  0);
    step("wr_sel3",      0, 0, 0, 32'h0,        1, 32'd3,        32'h12345678, 32'h11111111, 32'hCAFEF00D, 32'h33333333, 3,  1,   0,   1,  0);
    step("wr_selbig",    0, 0, 0, 32'h0,        1, 32'h80000000, 32'h12345678, 32'h11111111, 32'hCAFEF00D, 32'h33333333, 3,  1,   0,   1,  0);
    step("start_full",   0, 1, 0, 32'h0,        0, 32'd0,        32'h0,        32'h11111111, 32'hCAFEF00D, 32'h33333333, 0,  0,   0,   0,  1);
    step("collision",    0, 0, 1, 32'hAAAAAAAA, 1, 32'd0,        32'h55555555, 32'h55555555, 32'hCAFEF00D, 32'h33333333, 1,  0,   0,   0,  1);
    step("push_w1",      0, 0, 1, 32'h01010101, 0, 32'd0,        32'h0,        32'h55555555, 32'h01010101, 32'h33333333, 2,  0,   0,   0,  1);
    step("start_mid",    0, 1, 0, 32'h0,        0, 32'd0,        32'h0,        32'h55555555, 32'h01010101, 32'h33333333, 0,  0,   0,   0,  1);
    step("refill0",      0, 0, 1, 32'hA1A1A1A1, 0, 32'd0,        32'h0,        32'hA1A1A1A1, 32'h01010101, 32'h33333333, 1,  0,   0,   0,  1);
    step("refill1",      0, 0, 1, 32'hB2B2B2B2, 0, 32'd0,        32'h0,        32'hA1A1A1A1, 32'hB2B2B2B2, 32'h33333333, 2,  0,   0,   0,  1);
    step("refill2",      0, 0, 1, 32'hC3C3C3C3, 0, 32'd0,        32'h0,        32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 3,  1,   1,   0,  0);
    step("start2",       0, 1, 0, 32'h0,        0, 32'd0,        32'h0,        32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 0,  0,   0,   0,  1);
    step("push_d4",      0, 0, 1, 32'hD4D4D4D4, 0, 32'd0,        32'h0,        32'hD4D4D4D4, 32'hB2B2B2B2, 32'hC3C3C3C3, 1,  0,   0,   0,  1);
    step("push_wr_diff", 0, 0, 1, 32'hE5E5E5E5, 1, 32'd2,        32'h77777777, 32'hD4D4D4D4, 32'hE5E5E5E5, 32'h77777777, 2,  0,   0,   0,  1);
    step("last_start",   0, 1, 1, 32'hF6F6F6F6, 0, 32'd0,        32'h0,        32'hD4D4D4D4, 32'hE5E5E5E5, 32'hF6F6F6F6, 0,  0,   0,   0,  1);
    step("push_12",      0, 0, 1, 32'h12121212, 0, 32'd0,        32'h0,        32'h12121212, 32'hE5E5E5E5, 32'hF6F6F6F6, 1,  0,   0,   0,  1);
    step("push_34",      0, 0, 1, 32'h34343434, 0, 32'd0,        32'h0,        32'h12121212, 32'h34343434, 32'hF6F6F6F6, 2,  0,   0,   0,  1);
    step("rst_mid",      1, 0, 1, 32'h99999999, 0, 32'd0,        32'h0,        32'h0,        32'h0,        32'h0,        0,  0,   0,   0,  1);
    step("post_rst",     0, 0, 0, 32'h0,        0, 32'd0,        32'h0,        32'h0,        32'h0,        32'h0,        0,  0,   0,   0,  1);

    @(negedge clk);
    in_valid = 1'b0; wr_en = 1'b0; start = 1'b0; rst = 1'b0;

    // Let the monitor drain the queue within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety net in case the stimulus thread never completes.
  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_insertion.md
Name: mult_insertion

Overview:
- Write-side counterpart of the word-select mux used in the RLS datapath.
- Builds and holds a packed N-bit vector made of NW = N/nBits words of nBits each.
- Words are loaded two ways: an auto-incrementing stream with a valid/ready handshake, or direct addressed writes.
- The packed output has the same layout the select mux consumes: word i sits at out[i*nBits +: nBits], MSB-first [0:N-1] indexing.

Parameters:
- N, 100, total width of the packed output vector in bits.
- nBits, 32, width of one word; NW = N/nBits words (integer division), so the default gives NW = 3.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; restarts stream fill at word 0.
- in_valid  input  1  stream word present on in_data.
- in_ready  output  1  block can accept a stream word.
- in_data  input  nBits  stream word, [0:nBits-1].
- wr_en  input  1  addressed write strobe.
- wr_sel  input  32  addressed word index.
- wr_data  input  nBits  addressed write word, [0:nBits-1].
- out  output  N  packed vector, [0:N-1].
- count  output  32  next stream word index (0..NW).
- full  output  1  all NW words filled by the stream since the last start or reset.
- done  output  1  one-cycle pulse on the cycle full rises.
- sel_err  output  1  one-cycle pulse for an out-of-range addressed write.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out = 0, count = 0, full = 0, done = 0, sel_err = 0, state = FILL.
  - Reset has priority over every other input.
  - Reset during a partial fill discards all progress.
- All outputs are registered except in_ready.
  - in_ready = (state == FILL), combinational from state only, never from inputs.
- Word write latency: a write accepted at edge k is visible on out after edge k, i.e. in cycle k+1.
- Tail bits: bits out[NW*nBits .. N-1], which exist when N is not a multiple of nBits, are always 0 and never written.
- State FILL:
  - A transfer occurs when in_valid & in_ready; it writes word[count] = in_data and increments count.
  - If the accepted word was at count = NW-1: count becomes NW, state goes to FULL, full = 1, and done pulses for one cycle.
- State FULL:
  - in_ready = 0, so in_valid is ignored.
  - count holds at NW; full holds at 1.
- start:
  - From either state: next count = 0, full = 0, state = FILL.
  - Word contents are retained, not cleared.
  - If a stream transfer occurs in the same cycle as start (FILL state), the word is still written at the old count; the count and state updates from start override.
  - start in the same cycle as the final transfer: the word is written, done does not pulse, and state = FILL with count = 0.
- Addressed write (wr_en = 1):
  - If wr_sel < NW: word[wr_sel] = wr_data at the next edge.
  - If wr_sel >= NW: no write, and sel_err = 1 for one cycle.
  - Addressed writes never change count, full, or state, and are accepted in both FILL and FULL.
- Collision: if an addressed write and a stream transfer target the same word in the same cycle, the addressed write wins, but count still increments. If they target different words, both are written.
- count arithmetic: 32-bit unsigned; never exceeds NW and never wraps.

Test Plan:
- Reset and stream fill (defaults N=100, nBits=32): assert rst, then push 32'h11111111, 32'h22222222, 32'h33333333 on consecutive cycles with in_valid=1.
  - Required: count goes 1, 2, 3; done pulses exactly one cycle, in the cycle after the third push; full=1; in_ready=0.
  - Required: out[0:31]=32'h11111111, out[32:63]=32'h22222222, out[64:95]=32'h33333333, out[96:99]=0.
- Backpressure in FULL: with full=1, hold in_valid=1 with in_data=32'hDEADBEEF for 5 cycles.
  - Required: out unchanged, count=3, no done pulse.
- Addressed write and range check: wr_en=1, wr_sel=1, wr_data=32'hCAFEF00D, then wr_sel=3.
  - Required: word 1 = 32'hCAFEF00D the next cycle; the wr_sel=3 cycle gives a sel_err pulse and out unchanged; full stays 1.
- Collision: in FILL with count=0, push 32'hAAAAAAAA together with wr_en=1, wr_sel=0, wr_data=32'h55555555.
  - Required: word 0 = 32'h55555555; count=1.
- start mid-fill: after 2 pushes, pulse start with no push.
  - Required: count=0, full=0, in_ready=1, words 0 and 1 retained.
  - Then 3 new pushes: done pulses once, and the new values overwrite words 0-2.
- Reset mid-operation: with count=2, assert rst for 1 cycle.
  - Required: out=0, count=0, full=0; a push in the rst cycle is discarded.
